// File: rtl/decode32_if.sv
// Decoder stage bus: upstream instruction handshake plus the registered decoded bundle.
// The decoder sits on the slave modport and the driving environment sits on the master modport.
interface decode32_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic        itype_o;
  logic [1:0]  aluop_o;
  logic [1:0]  asel_o;
  logic        bsel_imm_o;
  logic [31:0] imm_o;
  logic        regwrite_o;
  logic        memread_o;
  logic        memwrite_o;
  logic        branch_o;
  logic        jump_o;
  logic        illegal_o;

  modport slave (
    input  valid_i, inst_i, pc_i, flush_i, ready_i,
    output ready_o, valid_o, pc_o, rs1_o, rs2_o, rd_o, funct3_o, funct7_o,
           itype_o, aluop_o, asel_o, bsel_imm_o, imm_o,
           regwrite_o, memread_o, memwrite_o, branch_o, jump_o, illegal_o
  );

  modport master (
    output valid_i, inst_i, pc_i, flush_i, ready_i,
    input  ready_o, valid_o, pc_o, rs1_o, rs2_o, rd_o, funct3_o, funct7_o,
           itype_o, aluop_o, asel_o, bsel_imm_o, imm_o,
           regwrite_o, memread_o, memwrite_o, branch_o, jump_o, illegal_o
  );
endinterface

// File: rtl/decode32.sv
// RV32I single-entry registered decode stage: decodes inst_i combinationally and
// holds the resulting bundle in one skid-free register with valid/ready flow control.
module decode32 (
  input  logic  clk_i,
  input  logic  reset_i,
  decode32_if.slave bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd2;
  localparam logic [1:0] ALU_FUNCT  = 2'd3;

  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        itype;
    logic [1:0]  aluop;
    logic [1:0]  asel;
    logic        bsel_imm;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  bundle_t     bundle_reg;
  bundle_t     bundle_next;
  logic        valid_reg;
  logic        ready;
  logic        accept;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = bus.inst_i[6:0];
  assign f3     = bus.inst_i[14:12];
  assign f7     = bus.inst_i[31:25];

  assign imm_i = {{20{bus.inst_i[31]}}, bus.inst_i[31:20]};
  assign imm_s = {{20{bus.inst_i[31]}}, bus.inst_i[31:25], bus.inst_i[11:7]};
  assign imm_b = {{19{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[7],
                  bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};
  assign imm_u = {bus.inst_i[31:12], 12'h000};
  assign imm_j = {{11{bus.inst_i[31]}}, bus.inst_i[31], bus.inst_i[19:12],
                  bus.inst_i[20], bus.inst_i[30:21], 1'b0};

  assign ready  = ~valid_reg | bus.ready_i;
  assign accept = bus.valid_i & ready & ~bus.flush_i;

  always_comb begin
    bundle_next        = '0;
    bundle_next.pc     = bus.pc_i;
    bundle_next.rs1    = bus.inst_i[19:15];
    bundle_next.rs2    = bus.inst_i[24:20];
    bundle_next.rd     = bus.inst_i[11:7];
    bundle_next.funct3 = f3;
    bundle_next.aluop  = ALU_ADD;
    bundle_next.asel   = ASEL_RS1;
    case (opcode)
      OP_LUI: begin
        bundle_next.asel     = ASEL_ZERO;
        bundle_next.bsel_imm = 1'b1;
        bundle_next.regwrite = 1'b1;
        bundle_next.imm      = imm_u;
      end
      OP_AUIPC: begin
        bundle_next.asel     = ASEL_PC;
        bundle_next.bsel_imm = 1'b1;
        bundle_next.regwrite = 1'b1;
        bundle_next.imm      = imm_u;
      end
      OP_JAL: begin
        bundle_next.asel     = ASEL_PC;
        bundle_next.bsel_imm = 1'b1;
        bundle_next.jump     = 1'b1;
        bundle_next.regwrite = 1'b1;
        bundle_next.imm      = imm_j;
      end
      OP_JALR: begin
        bundle_next.bsel_imm = 1'b1;
        bundle_next.jump     = 1'b1;
        bundle_next.regwrite = 1'b1;
        bundle_next.imm      = imm_i;
        bundle_next.illegal  = (f3 != 3'd0);
      end
      OP_BRANCH: begin
        bundle_next.aluop   = ALU_BRANCH;
        bundle_next.branch  = 1'b1;
        bundle_next.imm     = imm_b;
        bundle_next.illegal = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_LOAD: begin
        bundle_next.bsel_imm = 1'b1;
        bundle_next.memread  = 1'b1;
        bundle_next.regwrite = 1'b1;
        bundle_next.imm      = imm_i;
        bundle_next.illegal  = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OP_STORE: begin
        bundle_next.bsel_imm = 1'b1;
        bundle_next.memwrite = 1'b1;
        bundle_next.imm      = imm_s;
        bundle_next.illegal  = (f3 > 3'd2);
      end
      OP_OPIMM: begin
        bundle_next.aluop    = ALU_FUNCT;
        bundle_next.itype    = 1'b1;
        bundle_next.bsel_imm = 1'b1;
        bundle_next.regwrite = 1'b1;
        bundle_next.imm      = imm_i;
        // Only the shifts carry a funct7 qualifier (srai vs srli); other imm ops use those bits as immediate.
        if (f3 == 3'd1) begin
          bundle_next.funct7  = f7;
          bundle_next.illegal = (f7 != 7'h00);
        end else if (f3 == 3'd5) begin
          bundle_next.funct7  = f7;
          bundle_next.illegal = (f7 != 7'h00) && (f7 != 7'h20);
        end
      end
      OP_OP: begin
        bundle_next.aluop    = ALU_FUNCT;
        bundle_next.regwrite = 1'b1;
        bundle_next.funct7   = f7;
        bundle_next.illegal  = !((f7 == 7'h00) ||
                                 ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      default: begin
        bundle_next.illegal = 1'b1;
      end
    endcase
    // An illegal bundle still travels down the pipe but must have no side effects.
    if (bundle_next.illegal) begin
      bundle_next.regwrite = 1'b0;
      bundle_next.memread  = 1'b0;
      bundle_next.memwrite = 1'b0;
      bundle_next.branch   = 1'b0;
      bundle_next.jump     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_reg  <= 1'b0;
      bundle_reg <= '0;
    end else if (bus.flush_i) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg  <= 1'b1;
      bundle_reg <= bundle_next;
    end else if (valid_reg && bus.ready_i) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = valid_reg;
  assign bus.pc_o       = bundle_reg.pc;
  assign bus.rs1_o      = bundle_reg.rs1;
  assign bus.rs2_o      = bundle_reg.rs2;
  assign bus.rd_o       = bundle_reg.rd;
  assign bus.funct3_o   = bundle_reg.funct3;
  assign bus.funct7_o   = bundle_reg.funct7;
  assign bus.itype_o    = bundle_reg.itype;
  assign bus.aluop_o    = bundle_reg.aluop;
  assign bus.asel_o     = bundle_reg.asel;
  assign bus.bsel_imm_o = bundle_reg.bsel_imm;
  assign bus.imm_o      = bundle_reg.imm;
  assign bus.regwrite_o = bundle_reg.regwrite;
  assign bus.memread_o  = bundle_reg.memread;
  assign bus.memwrite_o = bundle_reg.memwrite;
  assign bus.branch_o   = bundle_reg.branch;
  assign bus.jump_o     = bundle_reg.jump;
  assign bus.illegal_o  = bundle_reg.illegal;

endmodule

// File: tb/tb_decode32.sv
// Self-checking bench for decode32: directed RV32I cases plus randomized traffic
// compared against a spec-level decode function and a one-entry stage model.
module tb_decode32;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        itype;
    logic [1:0]  aluop;
    logic [1:0]  asel;
    logic        bsel_imm;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic    exp_valid;
  bundle_t exp_b;

  decode32_if bus ();

  decode32 dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t b;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] si, ss, sb, sj;
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    si = $signed(inst[31:20]);
    ss = $signed({inst[31:25], inst[11:7]});
    sb = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    sj = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    b = '0;
    b.pc = pc;
    b.rs1 = inst[19:15];
    b.rs2 = inst[24:20];
    b.rd = inst[11:7];
    b.funct3 = f3;
    case (op)
      7'b0110111: begin b.asel = 2; b.bsel_imm = 1; b.regwrite = 1; b.imm = inst & 32'hFFFFF000; end
      7'b0010111: begin b.asel = 1; b.bsel_imm = 1; b.regwrite = 1; b.imm = inst & 32'hFFFFF000; end
      7'b1101111: begin b.asel = 1; b.bsel_imm = 1; b.jump = 1; b.regwrite = 1; b.imm = sj; end
      7'b1100111: begin
        b.bsel_imm = 1; b.jump = 1; b.regwrite = 1; b.imm = si;
        b.illegal = (f3 != 0);
      end
      7'b1100011: begin b.aluop = 2; b.branch = 1; b.imm = sb; b.illegal = f3 inside {3'd2, 3'd3}; end
      7'b0000011: begin
        b.bsel_imm = 1; b.memread = 1; b.regwrite = 1; b.imm = si;
        b.illegal = f3 inside {3'd3, 3'd6, 3'd7};
      end
      7'b0100011: begin b.bsel_imm = 1; b.memwrite = 1; b.imm = ss; b.illegal = (f3 > 2); end
      7'b0010011: begin
        b.aluop = 3; b.itype = 1; b.bsel_imm = 1; b.regwrite = 1; b.imm = si;
        if (f3 == 1 || f3 == 5) b.funct7 = f7;
        b.illegal = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
      end
      7'b0110011: begin
        b.aluop = 3; b.regwrite = 1; b.funct7 = f7;
        b.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
      end
      default: b.illegal = 1;
    endcase
    if (b.illegal) begin
      b.regwrite = 0; b.memread = 0; b.memwrite = 0; b.branch = 0; b.jump = 0;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  ops [9];
    int k;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) r[6:0] = ops[k];
    if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  function automatic bundle_t got_bundle();
    bundle_t g;
    g.pc = bus.pc_o;         g.rs1 = bus.rs1_o;       g.rs2 = bus.rs2_o;
    g.rd = bus.rd_o;         g.funct3 = bus.funct3_o; g.funct7 = bus.funct7_o;
    g.itype = bus.itype_o;   g.aluop = bus.aluop_o;   g.asel = bus.asel_o;
    g.bsel_imm = bus.bsel_imm_o; g.imm = bus.imm_o;   g.regwrite = bus.regwrite_o;
    g.memread = bus.memread_o;   g.memwrite = bus.memwrite_o;
    g.branch = bus.branch_o; g.jump = bus.jump_o;     g.illegal = bus.illegal_o;
    return g;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic rdy, input logic rs);
    bus.valid_i = v;
    bus.inst_i  = inst;
    bus.pc_i    = pc;
    bus.flush_i = fl;
    bus.ready_i = rdy;
    rst         = rs;
    #1;
  endtask

  // Advances one clock and updates the expected stage contents from the driven inputs.
  task automatic tick();
    logic rdy_exp;
    rdy_exp = !exp_valid || bus.ready_i;
    @(posedge clk);
    if (rst) begin
      exp_valid = 0;
      exp_b = '0;
    end else if (bus.flush_i) begin
      exp_valid = 0;
    end else if (bus.valid_i && rdy_exp) begin
      exp_b = ref_decode(bus.inst_i, bus.pc_i);
      exp_valid = 1;
    end else if (exp_valid && bus.ready_i) begin
      exp_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, $urandom, $urandom, 0, 0, 1);
    tick();
    tick();
    n_cmp++;
    if (bus.valid_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_o);
    end
    n_cmp++;
    if (got_bundle() !== bundle_t'(0)) begin
      n_bad++; $display("FAIL reset_bundle: got %h want 0", got_bundle());
    end
    n_cmp++;
    if (bus.ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", bus.ready_o);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] insts [4];
    bundle_t g;
    insts = '{32'hFFF08293, 32'h402081B3, 32'h123453B7, 32'h0000000B};
    for (int i = 0; i < 4; i++) begin
      drive(1, insts[i], 32'h1000 + 4 * i, 0, 1, 0);
      tick();
      g = got_bundle();
      n_cmp++;
      if (bus.valid_o !== 1'b1 || g !== exp_b) begin
        n_bad++;
        $display("FAIL directed_%0d: got v=%b %h want v=1 %h", i, bus.valid_o, g, exp_b);
      end
      case (i)
        0: begin
          n_cmp++;
          if ({g.aluop, g.itype, g.imm, g.rs1, g.rd, g.funct7, g.regwrite} !==
              {2'd3, 1'b1, 32'hFFFFFFFF, 5'd1, 5'd5, 7'd0, 1'b1}) begin
            n_bad++; $display("FAIL addi_fields: got %h", g);
          end
        end
        1: begin
          n_cmp++;
          if ({g.aluop, g.funct7, g.bsel_imm, g.rs2, g.illegal} !== {2'd3, 7'h20, 1'b0, 5'd2, 1'b0}) begin
            n_bad++; $display("FAIL sub_fields: got %h", g);
          end
        end
        2: begin
          n_cmp++;
          if ({g.imm, g.asel, g.aluop, g.rd} !== {32'h12345000, 2'd2, 2'd0, 5'd7}) begin
            n_bad++; $display("FAIL lui_fields: got %h", g);
          end
        end
        default: begin
          n_cmp++;
          if ({g.illegal, g.regwrite, g.memread, g.memwrite, g.branch, g.jump} !== 6'b100000) begin
            n_bad++; $display("FAIL illegal_fields: got %h", g);
          end
        end
      endcase
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 6; i++) begin
      drive(1, rand_inst(), 32'h2000 + 4 * i, 0, (i >= 4), 0);
      n_cmp++;
      if (bus.ready_o !== (!exp_valid || bus.ready_i)) begin
        n_bad++; $display("FAIL stall_ready_%0d: got %b want %b", i, bus.ready_o, !exp_valid || bus.ready_i);
      end
      tick();
      n_cmp++;
      if (bus.valid_o !== 1'b1 || got_bundle() !== exp_b) begin
        n_bad++; $display("FAIL stall_hold_%0d: got v=%b %h want v=1 %h", i, bus.valid_o, got_bundle(), exp_b);
      end
    end
    n_cmp++;
    if (bus.pc_o !== 32'h2014) begin
      n_bad++; $display("FAIL back_to_back_pc: got %h want 00002014", bus.pc_o);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_flush();
    drive(1, 32'h00000013, 32'h3000, 0, 0, 0);
    tick();
    drive(1, 32'h402081B3, 32'h3004, 1, 1, 0);
    tick();
    n_cmp++;
    if (bus.valid_o !== 1'b0 || got_bundle() !== exp_b) begin
      n_bad++; $display("FAIL flush: got v=%b %h want v=0 %h", bus.valid_o, got_bundle(), exp_b);
    end
    n_cmp++;
    if (bus.pc_o !== 32'h3000) begin
      n_bad++; $display("FAIL flush_drop: got pc %h want 00003000", bus.pc_o);
    end
    drive(1, 32'h123453B7, 32'h3008, 0, 1, 0);
    tick();
    n_cmp++;
    if (bus.valid_o !== 1'b1 || got_bundle() !== exp_b) begin
      n_bad++; $display("FAIL post_flush: got v=%b %h want v=1 %h", bus.valid_o, got_bundle(), exp_b);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 32'hFFF08293, 32'h4000, 0, 0, 0);
    tick();
    drive(1, 32'h402081B3, 32'h4004, 0, 0, 1);
    tick();
    n_cmp++;
    if (bus.valid_o !== 1'b0 || got_bundle() !== bundle_t'(0)) begin
      n_bad++; $display("FAIL reset_mid_stall: got v=%b %h want v=0 0", bus.valid_o, got_bundle());
    end
    drive(1, 32'h402081B3, 32'h4008, 0, 1, 0);
    tick();
    n_cmp++;
    if (bus.valid_o !== 1'b1 || got_bundle() !== exp_b) begin
      n_bad++; $display("FAIL after_reset_accept: got v=%b %h want v=1 %h", bus.valid_o, got_bundle(), exp_b);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      n_cmp++;
      if (bus.ready_o !== (!exp_valid || bus.ready_i)) begin
        n_bad++; $display("FAIL rand_ready_%0d: got %b want %b", i, bus.ready_o, !exp_valid || bus.ready_i);
      end
      tick();
      n_cmp++;
      if (bus.valid_o !== exp_valid || got_bundle() !== exp_b) begin
        n_bad++;
        $display("FAIL rand_out_%0d: got v=%b %h want v=%b %h", i, bus.valid_o, got_bundle(), exp_valid, exp_b);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_valid = 0;
    exp_b = '0;
    rst = 1;
    bus.valid_i = 0;
    bus.inst_i = 0;
    bus.pc_i = 0;
    bus.flush_i = 0;
    bus.ready_i = 0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
